raw_binning_debayer: RTL and testbench

RAW_BINNING_DEBAYER -- requirements
Module: raw_binning_debayer

---
 rtl/raw_binning_debayer.sv | 152 +++++++++++++++
 tb/tb_raw_binning_debayer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/raw_binning_debayer.sv
// raw_binning_debayer: 2x2 binning demosaic for RAW8 RGGB sensor data.
// Even (R/G) lines are buffered; each odd (G/B) word is combined with the
// buffered even word in the same column to give one RGB pixel per quad.
module raw_binning_debayer #(
   parameter int MAX_WORDS = 640,
   parameter int AW        = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_start,
   input  logic        raw_valid,
   input  logic [15:0] raw_data,
   output logic        rgb_valid,
   output logic [23:0] rgb_data,
   output logic        line_err,
   output logic        frame_active
);

   localparam logic [1:0]  WAIT_FRAME = 2'd0;
   localparam logic [1:0]  EVEN_LINE  = 2'd1;
   localparam logic [1:0]  ODD_LINE   = 2'd2;
   // Pointers carry one extra bit so a completely full line is representable.
   localparam logic [AW:0] MAX_PTR    = (AW+1)'(MAX_WORDS);

   logic [1:0]    state;
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [AW:0]   word_cnt;
   logic          prev_valid;

   logic [15:0]   line_mem [MAX_WORDS];

   logic          vld_p1;
   logic [15:0]   even_p1;
   logic [15:0]   odd_p1;

   logic          in_even;
   logic          in_odd;
   logic          eol;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic          rd_en;
   logic          drop;

   // Green is the mean of the two green samples; summed at 9 bits, truncated.
   function automatic logic [7:0] green_avg(input logic [7:0] g_even, input logic [7:0] g_odd);
      logic [8:0] sum;
      sum = {1'b0, g_even} + {1'b0, g_odd};
      return sum[8:1];
   endfunction

   // Pack one quad into {R, G, B}.
   function automatic logic [23:0] pack_rgb(input logic [15:0] even_w, input logic [15:0] odd_w);
      return {even_w[7:0], green_avg(even_w[15:8], odd_w[7:0]), odd_w[15:8]};
   endfunction

   // Decode this cycle's buffer access and error conditions.
   always_comb begin
      in_even = (state == EVEN_LINE);
      in_odd  = (state == ODD_LINE);
      eol     = prev_valid & ~raw_valid;
      // frame_start with raw_valid makes that word the first of the new even line.
      wr_en   = raw_valid & (frame_start | (in_even & (wr_ptr < MAX_PTR)));
      wr_addr = frame_start ? '0 : wr_ptr[AW-1:0];
      rd_en   = ~frame_start & in_odd & raw_valid & (rd_ptr < word_cnt);
      drop    = ~frame_start & raw_valid &
                ((in_even & (wr_ptr >= MAX_PTR)) | (in_odd & (rd_ptr >= word_cnt)));
   end

   // Line FSM, pointers, stored count and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= WAIT_FRAME;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         word_cnt     <= '0;
         prev_valid   <= 1'b0;
         line_err     <= 1'b0;
         frame_active <= 1'b0;
      end else if (frame_start) begin
         state        <= EVEN_LINE;
         wr_ptr       <= {{AW{1'b0}}, raw_valid};
         rd_ptr       <= '0;
         word_cnt     <= '0;
         prev_valid   <= raw_valid;
         line_err     <= 1'b0;
         frame_active <= 1'b1;
      end else begin
         // Words seen while waiting for a frame must not end a line later.
         prev_valid <= raw_valid & (state != WAIT_FRAME);
         if (drop) begin
            line_err <= 1'b1;
         end
         case (state)
            EVEN_LINE: begin
               if (eol) begin
                  state    <= ODD_LINE;
                  word_cnt <= wr_ptr;
                  wr_ptr   <= '0;
                  rd_ptr   <= '0;
               end else if (wr_en) begin
                  wr_ptr <= wr_ptr + 1'b1;
               end
            end
            ODD_LINE: begin
               if (eol) begin
                  state  <= EVEN_LINE;
                  rd_ptr <= '0;
               end else if (rd_en) begin
                  rd_ptr <= rd_ptr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // ---- stage p1: synchronous line buffer read alongside the odd word ----
   // Buffer storage and read data are never reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         line_mem[wr_addr] <= raw_data;
      end
      if (rd_en) begin
         even_p1 <= line_mem[rd_ptr[AW-1:0]];
         odd_p1  <= raw_data;
      end
   end

   // Valid for the p1 stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= rd_en;
      end
   end

   // ---- stage p2: output register; frame_start cancels the pixel in flight ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_valid <= 1'b0;
         rgb_data  <= 24'h0;
      end else begin
         rgb_valid <= vld_p1 & ~frame_start;
         if (vld_p1 & ~frame_start) begin
            rgb_data <= pack_rgb(even_p1, odd_p1);
         end
      end
   end

endmodule

// File: tb/tb_raw_binning_debayer.sv
// Self-checking bench for raw_binning_debayer: directed scenarios plus
// randomized frames, compared against a line-level reference model.
module tb_raw_binning_debayer;

   localparam int MAXW = 8;

   logic        clk;
   logic        rst_n;
   logic        frame_start;
   logic        raw_valid;
   logic [15:0] raw_data;
   logic        rgb_valid;
   logic [23:0] rgb_data;
   logic        line_err;
   logic        frame_active;

   raw_binning_debayer #(.MAX_WORDS(MAXW), .AW(3)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_start  (frame_start),
      .raw_valid    (raw_valid),
      .raw_data     (raw_data),
      .rgb_valid    (rgb_valid),
      .rgb_data     (rgb_data),
      .line_err     (line_err),
      .frame_active (frame_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected pixel and the step index at whose check it must be visible.
   typedef struct {
      int          due;
      logic [23:0] px;
   } pred_t;

   pred_t       pq[$];
   logic [15:0] even_q[$];
   logic [15:0] stored[$];
   int          mode;      // 0 waiting for frame, 1 even line, 2 odd line
   int          k;         // index of next odd word within the line
   bit          m_err;
   bit          m_act;
   bit          m_prev;
   bit          in_reset;
   int          s;
   int          total;
   int          passed;
   int          pix;
   int          pix0;

   function automatic logic [23:0] ref_px(input logic [15:0] e, input logic [15:0] o);
      int r, g, b;
      r = int'(e[7:0]);
      g = (int'(e[15:8]) + int'(o[7:0])) / 2;
      b = int'(o[15:8]);
      return 24'(r * 65536 + g * 256 + b);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference behaviour for one clock of input.
   task automatic model_cycle(input logic fs, input logic v, input logic [15:0] d);
      pred_t p;
      if (in_reset) return;
      if (fs) begin
         m_act = 1'b1;
         mode  = 1;
         even_q.delete();
         stored.delete();
         k     = 0;
         m_err = 1'b0;
         while (pq.size() > 0 && pq[pq.size()-1].due >= s) void'(pq.pop_back());
         if (v) even_q.push_back(d);
         m_prev = v;
         return;
      end
      if (mode == 0) return;
      if (m_prev && !v) begin
         if (mode == 1) begin
            stored = even_q;
            even_q.delete();
            k    = 0;
            mode = 2;
         end else begin
            mode = 1;
         end
      end else if (v) begin
         if (mode == 1) begin
            if (even_q.size() < MAXW) even_q.push_back(d);
            else m_err = 1'b1;
         end else begin
            if (k < stored.size()) begin
               p.due = s + 1;
               p.px  = ref_px(stored[k], d);
               pq.push_back(p);
               k++;
            end else begin
               m_err = 1'b1;
            end
         end
      end
      m_prev = v;
   endtask

   task automatic check_outputs();
      bit exp_v;
      exp_v = (pq.size() > 0) && (pq[0].due == s);
      chk("rgb_valid", 32'(rgb_valid), 32'(exp_v));
      if (exp_v) begin
         chk("rgb_data", 32'(rgb_data), 32'(pq[0].px));
         void'(pq.pop_front());
      end
      if (!rst_n) chk("rgb_data_in_reset", 32'(rgb_data), 32'h0);
      chk("line_err", 32'(line_err), 32'(m_err));
      chk("frame_active", 32'(frame_active), 32'(m_act));
      if (rgb_valid === 1'b1) pix++;
   endtask

   task automatic step(input logic fs, input logic v, input logic [15:0] d);
      frame_start = fs;
      raw_valid   = v;
      raw_data    = d;
      model_cycle(fs, v, d);
      @(posedge clk);
      #1;
      check_outputs();
      s++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
   endtask

   task automatic line(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 16'($urandom()));
   endtask

   task automatic model_reset();
      pq.delete();
      even_q.delete();
      stored.delete();
      mode   = 0;
      k      = 0;
      m_err  = 1'b0;
      m_act  = 1'b0;
      m_prev = 1'b0;
   endtask

   initial begin
      total = 0; passed = 0; pix = 0; s = 0;
      rst_n = 1'b0; frame_start = 1'b0; raw_valid = 1'b0; raw_data = 16'h0;
      in_reset = 1'b1;
      model_reset();

      // Reset state
      idle(3);
      rst_n = 1'b1;
      in_reset = 1'b0;
      idle(2);

      // Words before any frame_start are ignored
      pix0 = pix;
      line(10);
      idle(3);
      chk("preframe_active", 32'(frame_active), 32'h0);
      chk("preframe_pixels", 32'(pix - pix0), 32'h0);

      // Basic quad
      step(1'b1, 1'b0, 16'h0);
      step(1'b0, 1'b1, 16'h2010);
      step(1'b0, 1'b0, 16'h0);
      step(1'b0, 1'b1, 16'h4030);
      step(1'b0, 1'b0, 16'h0);
      chk("quad_valid", 32'(rgb_valid), 32'h1);
      chk("quad_rgb", 32'(rgb_data), 32'h102840);
      idle(2);

      // Green average without 8-bit overflow
      step(1'b1, 1'b0, 16'h0);
      step(1'b0, 1'b1, 16'hFF11);
      step(1'b0, 1'b0, 16'h0);
      step(1'b0, 1'b1, 16'h22FE);
      step(1'b0, 1'b0, 16'h0);
      chk("g_round_rgb", 32'(rgb_data), 32'h11FE22);
      idle(2);

      // Streaming: 4 even, 4 back-to-back odd words
      step(1'b1, 1'b0, 16'h0);
      line(4); idle(1);
      pix0 = pix;
      line(4); idle(4);
      chk("stream_pixels", 32'(pix - pix0), 32'd4);

      // Overlength odd line
      step(1'b1, 1'b0, 16'h0);
      line(3); idle(1);
      pix0 = pix;
      line(5); idle(4);
      chk("overlen_pixels", 32'(pix - pix0), 32'd3);
      chk("overlen_err", 32'(line_err), 32'h1);
      step(1'b1, 1'b0, 16'h0);
      chk("err_cleared", 32'(line_err), 32'h0);

      // Even line overflowing the buffer, then a full-length odd line
      line(MAXW + 2); idle(1);
      pix0 = pix;
      line(MAXW); idle(4);
      chk("overflow_pixels", 32'(pix - pix0), 32'(MAXW));

      // Short odd line raises no error
      step(1'b1, 1'b0, 16'h0);
      line(4); idle(1);
      line(2); idle(3);
      chk("short_no_err", 32'(line_err), 32'h0);

      // frame_start mid odd line with a word in the same cycle
      step(1'b1, 1'b0, 16'h0);
      line(4); idle(1);
      line(3);
      step(1'b1, 1'b1, 16'hA55A);
      line(2); idle(2);
      line(3); idle(4);

      // Randomized frames
      for (int f = 0; f < 8; f++) begin
         step(1'b1, 1'($urandom_range(1)), 16'($urandom()));
         for (int l = 0; l < 6; l++) begin
            int n;
            n = $urandom_range(MAXW + 2, 1);
            for (int i = 0; i < n; i++) begin
               if ($urandom_range(39) == 0) step(1'b1, 1'b1, 16'($urandom()));
               else step(1'b0, 1'b1, 16'($urandom()));
            end
            idle($urandom_range(3, 1));
         end
      end
      idle(3);

      // Reset during an odd line
      step(1'b1, 1'b0, 16'h0);
      line(4); idle(1);
      line(2);
      rst_n = 1'b0;
      in_reset = 1'b1;
      #1;
      model_reset();
      chk("rst_rgb_valid", 32'(rgb_valid), 32'h0);
      chk("rst_rgb_data", 32'(rgb_data), 32'h0);
      chk("rst_line_err", 32'(line_err), 32'h0);
      chk("rst_frame_active", 32'(frame_active), 32'h0);
      step(1'b0, 1'b1, 16'h1234);
      step(1'b0, 1'b1, 16'h5678);
      rst_n = 1'b1;
      in_reset = 1'b0;
      pix0 = pix;
      line(6); idle(1);
      line(4); idle(3);
      chk("post_rst_no_pixels", 32'(pix - pix0), 32'h0);
      step(1'b1, 1'b0, 16'h0);
      line(2); idle(1);
      pix0 = pix;
      line(2); idle(3);
      chk("post_rst_pixels", 32'(pix - pix0), 32'd2);
      chk("pending_drained", 32'(pq.size()), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
